// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the byte-RAM memory controller: FSM state encoding,
// load/store size encodings and the size-to-byte-count helper.
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Byte count for a load/store size code; the unused code 3 acts as a word.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SIZE_B:  n = 3'd1;
            SIZE_H:  n = 3'd2;
            SIZE_W:  n = 3'd4;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_ctrl_if
// Bundles the controller's request/response signals and byte-RAM port.
// Signal directions in the names are seen from the controller.
//   if_*   : instruction fetch request (4-byte read) and done/data
//   ls_*   : load/store request and done/zero-extended load data
//   flush_in : cancels an in-flight instruction fetch
//   ram_*  : byte RAM (enable, read/not-write, address, write data, read data)
// Modports: slave = controller, master = requester + RAM side.
// -----------------------------------------------------------------------------
interface mem_ctrl_if #(
    parameter int ADDR_WIDTH = 17
);
    logic                  if_req_in;
    logic [31:0]           if_addr_in;
    logic                  if_done_out;
    logic [31:0]           if_data_out;
    logic                  ls_req_in;
    logic                  ls_we_in;
    logic [1:0]            ls_size_in;
    logic [31:0]           ls_addr_in;
    logic [31:0]           ls_wdata_in;
    logic                  ls_done_out;
    logic [31:0]           ls_rdata_out;
    logic                  flush_in;
    logic                  ram_en_out;
    logic                  ram_r_nw_out;
    logic [ADDR_WIDTH-1:0] ram_a_out;
    logic [7:0]            ram_d_out;
    logic [7:0]            ram_d_in;

    modport slave (
        input  if_req_in, if_addr_in, ls_req_in, ls_we_in, ls_size_in,
               ls_addr_in, ls_wdata_in, flush_in, ram_d_in,
        output if_done_out, if_data_out, ls_done_out, ls_rdata_out,
               ram_en_out, ram_r_nw_out, ram_a_out, ram_d_out
    );

    modport master (
        output if_req_in, if_addr_in, ls_req_in, ls_we_in, ls_size_in,
               ls_addr_in, ls_wdata_in, flush_in, ram_d_in,
        input  if_done_out, if_data_out, ls_done_out, ls_rdata_out,
               ram_en_out, ram_r_nw_out, ram_a_out, ram_d_out
    );
endinterface

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Arbitrates instruction-fetch and load/store requests onto a byte-wide RAM
// with one-cycle read latency, sequencing multi-byte accesses one byte per
// cycle. Load/store wins over fetch; a flush aborts an in-flight fetch.
// Ports:
//   clk_in   : clock, rising edge
//   rst_n_in : asynchronous active-low reset
//   bus      : mem_ctrl_if.slave (requests, responses, RAM port)
// All outputs are registered; RAM controls are computed from next state.
// -----------------------------------------------------------------------------
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 17
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    mem_ctrl_if.slave   bus
);

    state_e                state_q, state_d;
    logic [2:0]            k_q, k_d;
    logic [2:0]            n_q, n_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  is_ls_q, is_ls_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rbuf_q, rbuf_d;
    logic                  if_done_q, if_done_d;
    logic                  ls_done_q, ls_done_d;
    logic [31:0]           if_data_q, if_data_d;
    logic [31:0]           ls_rdata_q, ls_rdata_d;
    logic                  ram_en_q, ram_en_d;
    logic                  ram_r_nw_q, ram_r_nw_d;
    logic [ADDR_WIDTH-1:0] ram_a_q, ram_a_d;
    logic [7:0]            ram_d_q, ram_d_d;

    // Only the low ADDR_WIDTH address bits reach the RAM.
    logic unused_addr_hi_s;
    assign unused_addr_hi_s = ^{bus.if_addr_in[31:ADDR_WIDTH], bus.ls_addr_in[31:ADDR_WIDTH]};

    // Next-state logic: arbitration, byte sequencing, read-buffer capture and done.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        n_d        = n_q;
        base_d     = base_q;
        is_ls_d    = is_ls_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.ls_req_in) begin
                    state_d = bus.ls_we_in ? WR : RD;
                    k_d     = 3'd0;
                    n_d     = size_to_bytes(bus.ls_size_in);
                    base_d  = bus.ls_addr_in[ADDR_WIDTH-1:0];
                    is_ls_d = 1'b1;
                    wdata_d = bus.ls_wdata_in;
                    rbuf_d  = 32'd0;
                end else if (bus.if_req_in && !bus.flush_in) begin
                    state_d = RD;
                    k_d     = 3'd0;
                    n_d     = 3'd4;
                    base_d  = bus.if_addr_in[ADDR_WIDTH-1:0];
                    is_ls_d = 1'b0;
                    rbuf_d  = 32'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            RD: begin
                if (!is_ls_q && bus.flush_in) begin
                    state_d = IDLE;
                end else begin
                    // RAM data seen now answers the address issued at k-1.
                    case (k_q)
                        3'd1:    rbuf_d[7:0]   = bus.ram_d_in;
                        3'd2:    rbuf_d[15:8]  = bus.ram_d_in;
                        3'd3:    rbuf_d[23:16] = bus.ram_d_in;
                        3'd4:    rbuf_d[31:24] = bus.ram_d_in;
                        default: rbuf_d        = rbuf_q;
                    endcase
                    if (k_q == n_q) begin
                        state_d = DONE;
                        if (is_ls_q) begin
                            ls_done_d  = 1'b1;
                            ls_rdata_d = rbuf_d;
                        end else begin
                            if_done_d = 1'b1;
                            if_data_d = rbuf_d;
                        end
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end
            end
            WR: begin
                if (k_q == n_q - 3'd1) begin
                    state_d   = DONE;
                    ls_done_d = 1'b1;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM port values for the coming cycle, derived from the next state.
    always_comb begin
        ram_en_d   = 1'b0;
        ram_r_nw_d = 1'b0;
        ram_a_d    = {ADDR_WIDTH{1'b0}};
        ram_d_d    = 8'd0;
        if ((state_d == RD) || (state_d == WR)) begin
            ram_en_d   = 1'b1;
            ram_r_nw_d = (state_d == RD);
            // Truncation to ADDR_WIDTH gives the modulo wrap.
            ram_a_d    = base_d + ADDR_WIDTH'(k_d);
            if (state_d == WR) begin
                case (k_d[1:0])
                    2'd0:    ram_d_d = wdata_d[7:0];
                    2'd1:    ram_d_d = wdata_d[15:8];
                    2'd2:    ram_d_d = wdata_d[23:16];
                    2'd3:    ram_d_d = wdata_d[31:24];
                    default: ram_d_d = 8'd0;
                endcase
            end else begin
                ram_d_d = 8'd0;
            end
        end else begin
            ram_en_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            k_q        <= 3'd0;
            n_q        <= 3'd0;
            base_q     <= {ADDR_WIDTH{1'b0}};
            is_ls_q    <= 1'b0;
            wdata_q    <= 32'd0;
            rbuf_q     <= 32'd0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= 32'd0;
            ls_rdata_q <= 32'd0;
            ram_en_q   <= 1'b0;
            ram_r_nw_q <= 1'b0;
            ram_a_q    <= {ADDR_WIDTH{1'b0}};
            ram_d_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            n_q        <= n_d;
            base_q     <= base_d;
            is_ls_q    <= is_ls_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
            ram_en_q   <= ram_en_d;
            ram_r_nw_q <= ram_r_nw_d;
            ram_a_q    <= ram_a_d;
            ram_d_q    <= ram_d_d;
        end
    end

    assign bus.if_done_out  = if_done_q;
    assign bus.if_data_out  = if_data_q;
    assign bus.ls_done_out  = ls_done_q;
    assign bus.ls_rdata_out = ls_rdata_q;
    assign bus.ram_en_out   = ram_en_q;
    assign bus.ram_r_nw_out = ram_r_nw_q;
    assign bus.ram_a_out    = ram_a_q;
    assign bus.ram_d_out    = ram_d_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
// Self-checking bench for mem_ctrl: a byte-RAM model with one-cycle read
// latency, directed scenarios (reset, fetch, wrap write, byte load,
// arbitration, flush, mid-write reset) and randomized transactions checked
// against a byte-array reference model.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int AW    = 17;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic rst_n;

    mem_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    mem_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // RAM model contents: bytes never written read back a fixed address hash.
    logic [7:0] mem     [0:DEPTH-1];
    bit         mem_wr  [0:DEPTH-1];
    logic [7:0] ref_mem [0:DEPTH-1];
    bit         ref_wr  [0:DEPTH-1];

    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [7:0]    pl_data;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_if = 32'd0;
    logic [31:0] last_ls = 32'd0;

    function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ {7'd0, a[16]} ^ 8'h3C;
    endfunction

    function automatic logic [7:0] dut_byte(input logic [AW-1:0] a);
        return mem_wr[a] ? mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [AW-1:0] a);
        return ref_wr[a] ? ref_mem[a] : init_byte(a);
    endfunction

    // Synchronous byte RAM: write when enabled and not reading, read data next cycle.
    always @(posedge clk) begin
        if (bus.ram_en_out && !bus.ram_r_nw_out) begin
            mem[bus.ram_a_out]    <= bus.ram_d_out;
            mem_wr[bus.ram_a_out] <= 1'b1;
        end else if (pl_en) begin
            mem[pl_addr]    <= pl_data;
            mem_wr[pl_addr] <= 1'b1;
        end
        bus.ram_d_in <= (bus.ram_en_out && bus.ram_r_nw_out) ? dut_byte(bus.ram_a_out) : 8'd0;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int size_bytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr, input int n);
        logic [31:0]   r;
        logic [AW-1:0] a;
        r = 32'd0;
        for (int i = 0; i < n; i++) begin
            a = addr[AW-1:0] + AW'(i);
            r[8*i +: 8] = ref_byte(a);
        end
        return r;
    endfunction

    task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
        ref_mem[a] = d; ref_wr[a] = 1'b1;
    endtask

    // Waits for the chosen done pulse; cnt = cycles since request, 0 on timeout.
    task automatic wait_done(input bit want_ls, output int cnt);
        cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (want_ls) check_eq("no_if_done", 32'(bus.if_done_out), 32'd0);
            else         check_eq("no_ls_done", 32'(bus.ls_done_out), 32'd0);
            if ((want_ls ? bus.ls_done_out : bus.if_done_out) == 1'b1) begin
                cnt = c;
                break;
            end
        end
    endtask

    task automatic run_if(input logic [31:0] addr);
        int cnt;
        logic [31:0] exp;
        exp = model_read(addr, 4);
        bus.if_addr_in = addr;
        bus.if_req_in  = 1'b1;
        wait_done(1'b0, cnt);
        check_eq("if_lat", 32'(cnt), 32'd6);
        check_eq("if_data", bus.if_data_out, exp);
        check_eq("ls_hold", bus.ls_rdata_out, last_ls);
        last_if = exp;
        bus.if_req_in = 1'b0;
        @(negedge clk);
        check_eq("if_pulse", 32'(bus.if_done_out), 32'd0);
        check_eq("en_idle", 32'(bus.ram_en_out), 32'd0);
    endtask

    task automatic run_ls(input logic we, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic fl);
        int cnt;
        int n;
        logic [31:0]   exp;
        logic [AW-1:0] a;
        n   = size_bytes(size);
        exp = model_read(addr, n);
        bus.ls_we_in = we; bus.ls_size_in = size; bus.ls_addr_in = addr;
        bus.ls_wdata_in = wdata; bus.flush_in = fl; bus.ls_req_in = 1'b1;
        wait_done(1'b1, cnt);
        check_eq(we ? "wr_lat" : "rd_lat", 32'(cnt), we ? 32'(n + 1) : 32'(n + 2));
        if (we) begin
            for (int i = 0; i < n; i++) begin
                a = addr[AW-1:0] + AW'(i);
                ref_mem[a] = wdata[8*i +: 8]; ref_wr[a] = 1'b1;
                check_eq("wr_byte", 32'(dut_byte(a)), 32'(wdata[8*i +: 8]));
            end
            check_eq("ls_hold", bus.ls_rdata_out, last_ls);
        end else begin
            check_eq("ls_rdata", bus.ls_rdata_out, exp);
            last_ls = exp;
        end
        check_eq("if_hold", bus.if_data_out, last_if);
        bus.ls_req_in = 1'b0; bus.flush_in = 1'b0;
        @(negedge clk);
        check_eq("ls_pulse", 32'(bus.ls_done_out), 32'd0);
        check_eq("en_idle", 32'(bus.ram_en_out), 32'd0);
    endtask

    initial begin
        int ls_at, if_at, cnt;
        logic [31:0] addr;
        logic [1:0]  size;

        clk = 1'b0; rst_n = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = 8'd0;
        bus.if_req_in = 1'b0; bus.if_addr_in = 32'd0; bus.ls_req_in = 1'b0;
        bus.ls_we_in = 1'b0; bus.ls_size_in = 2'd0; bus.ls_addr_in = 32'd0;
        bus.ls_wdata_in = 32'd0; bus.flush_in = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_en", 32'(bus.ram_en_out), 32'd0);
        check_eq("rst_rnw", 32'(bus.ram_r_nw_out), 32'd0);
        check_eq("rst_if_done", 32'(bus.if_done_out), 32'd0);
        check_eq("rst_ls_done", 32'(bus.ls_done_out), 32'd0);
        check_eq("rst_if_data", bus.if_data_out, 32'd0);
        preload(17'h00100, 8'h13);
        preload(17'h00101, 8'h05);
        preload(17'h00102, 8'h00);
        preload(17'h00103, 8'h00);
        preload(17'h00010, 8'h80);
        rst_n = 1'b1;
        @(negedge clk);

        // Fetch of a known instruction word
        run_if(32'h0000_0100);
        check_eq("if_word_0x513", bus.if_data_out, 32'h0000_0513);

        // Half-word store across the address wrap, then word store across it
        run_ls(1'b1, SIZE_H, 32'h0001_FFFF, 32'hAABB_CCDD, 1'b0);
        check_eq("wrap_hi", 32'(dut_byte(17'h1FFFF)), 32'h0000_00DD);
        check_eq("wrap_lo", 32'(dut_byte(17'h00000)), 32'h0000_00CC);
        run_ls(1'b1, SIZE_W, 32'hFFFF_FFFE, 32'h1234_5678, 1'b0);
        run_ls(1'b0, 2'd3, 32'h0001_FFFE, 32'd0, 1'b0);
        check_eq("size3_word", bus.ls_rdata_out, 32'h1234_5678);

        // Byte load, zero-extended
        run_ls(1'b0, SIZE_B, 32'h0000_0010, 32'd0, 1'b0);
        check_eq("ld_byte_0x80", bus.ls_rdata_out, 32'h0000_0080);

        // Simultaneous requests: load first, fetch only after DONE
        bus.ls_we_in = 1'b0; bus.ls_size_in = SIZE_B; bus.ls_addr_in = 32'h0000_0010;
        bus.if_addr_in = 32'h0000_0100;
        bus.ls_req_in = 1'b1; bus.if_req_in = 1'b1;
        ls_at = 0; if_at = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.ls_done_out) begin
                ls_at = c;
                bus.ls_req_in = 1'b0;
            end
            if (ls_at != 0 && c == ls_at + 1) check_eq("no_accept_in_done", 32'(bus.ram_en_out), 32'd0);
            if (bus.if_done_out) begin
                if_at = c;
                break;
            end
        end
        check_eq("arb_ls_lat", 32'(ls_at), 32'd3);
        check_eq("arb_if_lat", 32'(if_at), 32'd10);
        check_eq("arb_ls_data", bus.ls_rdata_out, model_read(32'h10, 1));
        check_eq("arb_if_data", bus.if_data_out, model_read(32'h100, 4));
        last_ls = model_read(32'h10, 1);
        last_if = model_read(32'h100, 4);
        bus.if_req_in = 1'b0;
        @(negedge clk);

        // Flush in IDLE blocks fetch acceptance for that cycle
        bus.if_addr_in = 32'h0000_0100; bus.if_req_in = 1'b1; bus.flush_in = 1'b1;
        @(negedge clk);
        check_eq("flush_idle_block", 32'(bus.ram_en_out), 32'd0);
        bus.flush_in = 1'b0;
        wait_done(1'b0, cnt);
        check_eq("post_flush_if_lat", 32'(cnt), 32'd6);
        bus.if_req_in = 1'b0;
        @(negedge clk);

        // Flush at RD k=2 aborts the fetch
        bus.if_addr_in = 32'h0000_0200; bus.if_req_in = 1'b1;
        repeat (3) @(negedge clk);
        bus.flush_in = 1'b1;
        @(negedge clk);
        check_eq("flush_abort_en", 32'(bus.ram_en_out), 32'd0);
        check_eq("flush_abort_done", 32'(bus.if_done_out), 32'd0);
        bus.flush_in = 1'b0; bus.if_req_in = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_eq("flush_no_done", 32'(bus.if_done_out), 32'd0);
        end
        check_eq("flush_if_hold", bus.if_data_out, last_if);

        // Flush is ignored by a store
        run_ls(1'b1, SIZE_W, 32'h0000_0400, 32'hCAFE_F00D, 1'b1);

        // Reset at WR k=1: outputs clear at once, no done, byte 0 already written
        bus.ls_we_in = 1'b1; bus.ls_size_in = SIZE_W; bus.ls_addr_in = 32'h0000_0ABC;
        bus.ls_wdata_in = 32'h1122_3344; bus.ls_req_in = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_en", 32'(bus.ram_en_out), 32'd0);
        check_eq("mid_rst_a", 32'(bus.ram_a_out), 32'd0);
        check_eq("mid_rst_d", 32'(bus.ram_d_out), 32'd0);
        check_eq("mid_rst_ls_data", bus.ls_rdata_out, 32'd0);
        bus.ls_req_in = 1'b0;
        ref_mem[17'h00ABC] = 8'h44; ref_wr[17'h00ABC] = 1'b1;
        last_if = 32'd0; last_ls = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("post_rst_no_done", 32'(bus.ls_done_out), 32'd0);
            check_eq("post_rst_en", 32'(bus.ram_en_out), 32'd0);
        end
        check_eq("partial_b0", 32'(dut_byte(17'h00ABC)), 32'h0000_0044);
        check_eq("partial_b1", 32'(dut_byte(17'h00ABD)), 32'(ref_byte(17'h00ABD)));

        // Randomized transactions, biased toward the wrap boundary
        for (int t = 0; t < 60; t++) begin
            addr = $urandom;
            if ($urandom_range(0, 3) == 0) addr[AW-1:0] = 17'h1FFFC + AW'($urandom_range(0, 3));
            size = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       run_if(addr);
                1:       run_ls(1'b0, size, addr, 32'd0, 1'($urandom_range(0, 1)));
                default: run_ls(1'b1, size, addr, $urandom, 1'($urandom_range(0, 1)));
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
